// File: rtl/i2s2_pkg.sv
`default_nettype none
//============================================================================
// i2s2_pkg : state encoding, widths and gain constants for the I2S2 path
// Rev 1.0 - initial release
//============================================================================
package i2s2_pkg;

  localparam int SAMPLE_W = 24;
  localparam int GAIN_W   = 9;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;
  localparam logic [GAIN_W-1:0] GAIN_STEP  = 9'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  // One ramp step toward silence (mute) or toward unity gain (unmute).
  function automatic logic [GAIN_W-1:0] gain_next(input logic [GAIN_W-1:0] gain,
                                                  input logic              mute_req);
    logic [GAIN_W-1:0] w_res;
    if (mute_req)
      w_res = (gain > GAIN_STEP) ? gain - GAIN_STEP : '0;
    else
      w_res = (gain < GAIN_UNITY - GAIN_STEP) ? gain + GAIN_STEP : GAIN_UNITY;
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s2_gain_stage.sv
`default_nettype none
//============================================================================
// i2s2_gain_stage : signed sample x unsigned gain, >>>8, registered output
// Rev 1.0 - initial release
//============================================================================
module i2s2_gain_stage
  import i2s2_pkg::*;
(
  input  logic                MCLK,
  input  logic                RESETN,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic [GAIN_W-1:0]   in_gain,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid
);

  logic signed [SAMPLE_W+GAIN_W:0] w_prod;

  assign w_prod = $signed(in_sample) * $signed({1'b0, in_gain});

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_data  <= in_valid ? SAMPLE_W'(w_prod >>> 8) : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s2_path_ctrl.sv
`default_nettype none
//============================================================================
// i2s2_path_ctrl : selects live RX or host frames for the I2S TX, frame-
// aligned source/mute switching. Soft-mute ramp under I2S2_SOFT_MUTE_EN.
// Rev 1.0 - initial release
//============================================================================
module i2s2_path_ctrl
  import i2s2_pkg::*;
(
  input  logic                  MCLK,
  input  logic                  RESETN,
  input  logic                  enable,
  input  logic                  src_sel,
  input  logic                  mute,
  input  logic                  rx_valid,
  input  logic                  rx_is_right,
  input  logic [SAMPLE_W-1:0]   rx_data,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [2*SAMPLE_W-1:0] host_data,
  input  logic                  tx_req,
  input  logic                  tx_is_right,
  output logic [SAMPLE_W-1:0]   tx_data,
  output logic                  tx_valid,
  output logic [1:0]            state,
  output logic [7:0]            underrun_cnt
);

  state_t                r_state, w_state_nxt;
  logic                  w_serve, w_left;
  logic                  r_src_host, r_underrun;
  logic                  w_src_host, w_underrun;
  logic [SAMPLE_W-1:0]   r_live_l, r_live_r, w_sample;
  logic                  r_host_full, w_host_take, w_host_pop;
  logic [2*SAMPLE_W-1:0] r_host_data;
  logic [7:0]            r_underrun_cnt;

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_serve     = 1'b0;
    case (r_state)
      ST_IDLE: if (enable) w_state_nxt = ST_ARM;
      ST_ARM: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (tx_req && !tx_is_right) begin
          w_serve     = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_serve = tx_req;
        if (!enable) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        w_serve = tx_req;
        if (tx_req && tx_is_right) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A left request is the frame boundary: the new source/underrun verdict
  // applies to this very request, then stays latched for the right half.
  assign w_left     = w_serve && !tx_is_right;
  assign w_src_host = w_left ? src_sel : r_src_host;
  assign w_underrun = w_left ? (src_sel && !r_host_full) : r_underrun;

  always_comb begin
    w_sample = '0;
    if (!w_src_host)
      w_sample = tx_is_right ? r_live_r : r_live_l;
    else if (!w_underrun && r_host_full)
      w_sample = tx_is_right ? r_host_data[SAMPLE_W-1:0]
                             : r_host_data[2*SAMPLE_W-1:SAMPLE_W];
  end

  assign host_ready  = !r_host_full;
  assign w_host_take = host_valid && !r_host_full;
  assign w_host_pop  = w_serve && tx_is_right && w_src_host && !w_underrun && r_host_full;

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      r_live_l       <= '0;
      r_live_r       <= '0;
      r_host_full    <= 1'b0;
      r_host_data    <= '0;
      r_src_host     <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      if (rx_valid && !rx_is_right) r_live_l <= rx_data;
      if (rx_valid &&  rx_is_right) r_live_r <= rx_data;
      if (w_host_take) begin
        r_host_full <= 1'b1;
        r_host_data <= host_data;
      end else if (w_host_pop) begin
        r_host_full <= 1'b0;
      end
      if (w_left) begin
        r_src_host <= src_sel;
        r_underrun <= w_underrun;
        if (w_underrun && r_underrun_cnt != 8'hFF)
          r_underrun_cnt <= r_underrun_cnt + 8'd1;
      end
    end
  end

`ifdef I2S2_SOFT_MUTE_EN
  logic [GAIN_W-1:0] r_gain, w_gain;

  assign w_gain = w_left ? gain_next(r_gain, mute) : r_gain;

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) r_gain <= GAIN_UNITY;
    else         r_gain <= w_gain;
  end

  i2s2_gain_stage u_gain_stage (
    .MCLK      (MCLK),
    .RESETN    (RESETN),
    .in_valid  (w_serve),
    .in_sample (w_sample),
    .in_gain   (w_gain),
    .out_data  (tx_data),
    .out_valid (tx_valid)
  );
`else
  logic r_frame_mute, w_mute;

  assign w_mute = w_left ? mute : r_frame_mute;

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      r_frame_mute <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
    end else begin
      r_frame_mute <= w_mute;
      tx_valid     <= w_serve;
      tx_data      <= (w_serve && !w_mute) ? w_sample : '0;
    end
  end
`endif

  assign state        = r_state;
  assign underrun_cnt = r_underrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_i2s2_path_ctrl.sv
`default_nettype none
//============================================================================
// tb_i2s2_path_ctrl : directed + randomized bench with a frame-level model
// Rev 1.0 - initial release
//============================================================================
module tb_i2s2_path_ctrl;

  logic        MCLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        enable = 1'b0, src_sel = 1'b0, mute = 1'b0;
  logic        rx_valid = 1'b0, rx_is_right = 1'b0;
  logic [23:0] rx_data = '0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [47:0] host_data = '0;
  logic        tx_req = 1'b0, tx_is_right = 1'b0;
  logic [23:0] tx_data;
  logic        tx_valid;
  logic [1:0]  state;
  logic [7:0]  underrun_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: what the listener should hear, frame by frame.
  logic [23:0] m_live_l, m_live_r;
  logic        m_host_full;
  logic [47:0] m_host;
  logic        m_src, m_mute, m_under;
  int          m_cnt, m_gain;

  i2s2_path_ctrl dut (
    .MCLK(MCLK), .RESETN(RESETN), .enable(enable), .src_sel(src_sel), .mute(mute),
    .rx_valid(rx_valid), .rx_is_right(rx_is_right), .rx_data(rx_data),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
    .tx_req(tx_req), .tx_is_right(tx_is_right), .tx_data(tx_data), .tx_valid(tx_valid),
    .state(state), .underrun_cnt(underrun_cnt)
  );

  always #22 MCLK = ~MCLK;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic model_reset();
    m_live_l = '0; m_live_r = '0; m_host_full = 1'b0; m_host = '0;
    m_src = 1'b0; m_mute = 1'b0; m_under = 1'b0; m_cnt = 0; m_gain = 256;
  endtask

  function automatic logic [23:0] m_out(input logic [23:0] s);
`ifdef I2S2_SOFT_MUTE_EN
    longint p;
    p = longint'($signed(s)) * m_gain;
    p = p >>> 8;
    return 24'(p);
`else
    return m_mute ? 24'd0 : s;
`endif
  endfunction

  task automatic serve(input logic right, input logic [23:0] exp, input string tag);
    tx_req = 1'b1; tx_is_right = right;
    step();
    tx_req = 1'b0;
    chk({tag, "_valid"}, 64'(tx_valid), 64'd1);
    chk({tag, "_data"}, 64'(tx_data), 64'(exp));
  endtask

  task automatic send_rx(input logic right, input logic [23:0] d);
    rx_valid = 1'b1; rx_is_right = right; rx_data = d;
    step();
    rx_valid = 1'b0;
    if (right) m_live_r = d; else m_live_l = d;
  endtask

  task automatic push_host(input logic [47:0] f);
    chk("host_ready_empty", 64'(host_ready), 64'd1);
    host_valid = 1'b1; host_data = f;
    step();
    host_valid = 1'b0;
    m_host_full = 1'b1; m_host = f;
    chk("host_ready_full", 64'(host_ready), 64'd0);
  endtask

  task automatic frame_left(input string tag);
    logic [23:0] s;
    m_src  = src_sel;
    m_mute = mute;
    if (mute) m_gain = (m_gain > 16) ? m_gain - 16 : 0;
    else      m_gain = (m_gain + 16 > 256) ? 256 : m_gain + 16;
    m_under = m_src && !m_host_full;
    if (m_under && m_cnt < 255) m_cnt++;
    s = m_src ? (m_under ? 24'd0 : m_host[47:24]) : m_live_l;
    serve(1'b0, m_out(s), tag);
    chk({tag, "_ucnt"}, 64'(underrun_cnt), 64'(m_cnt));
  endtask

  task automatic frame_right(input string tag);
    logic [23:0] s;
    s = m_src ? ((m_under || !m_host_full) ? 24'd0 : m_host[23:0]) : m_live_r;
    if (m_src && !m_under && m_host_full) m_host_full = 1'b0;
    serve(1'b1, m_out(s), tag);
  endtask

  initial begin
    logic [47:0] hf;

    // Reset state
    model_reset();
    #3;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_data", 64'(tx_data), 64'd0);
    chk("rst_ucnt", 64'(underrun_cnt), 64'd0);
    step();
    RESETN = 1'b1;
    step();
    chk("rst_ready", 64'(host_ready), 64'd1);
    chk("idle_state", 64'(state), 64'd0);

    // Live passthrough
    enable = 1'b1;
    step();
    chk("arm_state", 64'(state), 64'd1);
    send_rx(1'b0, 24'h123456);
    send_rx(1'b1, 24'hFEDCBA);
    frame_left("pass_L");
    chk("run_state", 64'(state), 64'd2);
    chk("pass_L_const", 64'(tx_data), 64'h123456);
    frame_right("pass_R");
    chk("pass_R_const", 64'(tx_data), 64'hFEDCBA);
    step();
    chk("strobe_one_cycle", 64'(tx_valid), 64'd0);

    // rx_valid coincident with a request returns the previous value
    rx_valid = 1'b1; rx_is_right = 1'b0; rx_data = 24'h111111;
    frame_left("rxcoinc_L");
    rx_valid = 1'b0; m_live_l = 24'h111111;
    chk("rxcoinc_const", 64'(tx_data), 64'h123456);
    frame_right("rxcoinc_R");
    frame_left("rxnew_L");
    frame_right("rxnew_R");

    // Source switch mid-frame takes effect at the next left request
    push_host(48'h0AAAAA_055555);
    src_sel = 1'b0;
    frame_left("sw_L_live");
    src_sel = 1'b1;
    frame_right("sw_R_live");
    chk("sw_R_const", 64'(tx_data), 64'hFEDCBA);
    frame_left("sw_L_host");
    chk("sw_L_host_const", 64'(tx_data), 64'h0AAAAA);
    frame_right("sw_R_host");
    chk("sw_R_host_const", 64'(tx_data), 64'h055555);
    chk("sw_ready_after", 64'(host_ready), 64'd1);

    // Underrun with host data arriving mid-frame
    frame_left("ur_L");
    chk("ur_cnt1", 64'(underrun_cnt), 64'd1);
    push_host(48'h0BBBBB_0CCCCC);
    frame_right("ur_R");
    frame_left("ur_next_L");
    frame_right("ur_next_R");
    chk("ur_next_R_const", 64'(tx_data), 64'h0CCCCC);
    for (int i = 0; i < 300; i++) begin
      frame_left("ur_sat_L");
      frame_right("ur_sat_R");
    end
    chk("ur_saturated", 64'(underrun_cnt), 64'd255);

    // Frame mute, mid-frame change deferred to the next frame
    src_sel = 1'b0; mute = 1'b1;
    frame_left("mute_L");
    mute = 1'b0;
    frame_right("mute_R");
    frame_left("unmute_L");
    frame_right("unmute_R");

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 1) == 1) send_rx(1'b0, 24'($urandom()));
      if ($urandom_range(0, 1) == 1) send_rx(1'b1, 24'($urandom()));
      if (!m_host_full && $urandom_range(0, 2) != 0) begin
        hf = {16'($urandom()), 32'($urandom())};
        push_host(hf);
      end
      src_sel = 1'($urandom_range(0, 1));
      mute    = ($urandom_range(0, 3) == 0);
      frame_left("rnd_L");
      if (!m_host_full && $urandom_range(0, 1) == 1) begin
        hf = {16'($urandom()), 32'($urandom())};
        push_host(hf);
      end
      src_sel = 1'($urandom_range(0, 1));
      mute    = ($urandom_range(0, 3) == 0);
      frame_right("rnd_R");
    end
    mute = 1'b0;

    // Stop completes the frame, ignores enable, then idles
    src_sel = 1'b0;
    frame_left("stop_L");
    enable = 1'b0;
    step();
    chk("stop_state", 64'(state), 64'd3);
    enable = 1'b1;
    step();
    chk("stop_ignores_en", 64'(state), 64'd3);
    enable = 1'b0;
    frame_right("stop_R");
    chk("stop_to_idle", 64'(state), 64'd0);
    tx_req = 1'b1; tx_is_right = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_no_valid", 64'(tx_valid), 64'd0);
      chk("idle_data_zero", 64'(tx_data), 64'd0);
    end
    tx_req = 1'b0;

    // Reset between left and right requests
    enable = 1'b1;
    step();
    if (!m_host_full) push_host(48'h0DDDDD_0EEEEE);
    chk("pre_rst_ready", 64'(host_ready), 64'd0);
    frame_left("rstmid_L");
    tx_req = 1'b1; tx_is_right = 1'b1;
    #2;
    RESETN = 1'b0; enable = 1'b0;
    #2;
    chk("rstmid_state", 64'(state), 64'd0);
    chk("rstmid_data", 64'(tx_data), 64'd0);
    chk("rstmid_ucnt", 64'(underrun_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstmid_no_valid", 64'(tx_valid), 64'd0);
    end
    tx_req = 1'b0;
    RESETN = 1'b1;
    model_reset();
    step();
    chk("rstmid_ready", 64'(host_ready), 64'd1);
    chk("rstmid_idle", 64'(state), 64'd0);

`ifdef I2S2_SOFT_MUTE_EN
    // Soft-mute ramp down and back up
    enable = 1'b1; src_sel = 1'b0;
    step();
    send_rx(1'b0, 24'h100000);
    send_rx(1'b1, 24'h100000);
    mute = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      serve(1'b0, 24'((16 - k) * 24'h010000), "ramp_dn_L");
      serve(1'b1, 24'((16 - k) * 24'h010000), "ramp_dn_R");
    end
    mute = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      serve(1'b0, 24'(k * 24'h010000), "ramp_up_L");
      serve(1'b1, 24'(k * 24'h010000), "ramp_up_R");
    end
    serve(1'b0, 24'h100000, "ramp_hold_L");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
